// File: rtl/intersection_scheduler_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// intersection_scheduler_pkg : phase codes, lamp/mode codes, decode helper
// Rev 1.0
// ------------------------------------------------------------------
package intersection_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_CLR_V = 3'd0,
      ST_V_GRN = 3'd1,
      ST_V_YEL = 3'd2,
      ST_CLR_B = 3'd3,
      ST_B_GRN = 3'd4,
      ST_B_YEL = 3'd5,
      ST_FLASH = 3'd6,
      ST_HOLD  = 3'd7
   } state_t;

   localparam logic [2:0] c_RED = 3'b100;
   localparam logic [2:0] c_YEL = 3'b010;
   localparam logic [2:0] c_GRN = 3'b001;
   localparam logic [2:0] c_OFF = 3'b000;

   localparam logic [1:0] c_MODE_FLASH = 2'b01;
   localparam logic [1:0] c_MODE_HOLD  = 2'b10;

   function automatic logic is_normal(input logic [1:0] mode);
      return (mode == 2'b00) || (mode == 2'b11);
   endfunction

   // Lamp pattern for one approach; side_b selects which approach is decoded.
   function automatic logic [2:0] light_of(input state_t s, input logic side_b,
                                           input logic flash_on);
      logic [2:0] l;
      l = c_RED;
      if (s == ST_FLASH)
         l = flash_on ? c_YEL : c_OFF;
      else if (!side_b && s == ST_V_GRN)
         l = c_GRN;
      else if (!side_b && s == ST_V_YEL)
         l = c_YEL;
      else if (side_b && s == ST_B_GRN)
         l = c_GRN;
      else if (side_b && s == ST_B_YEL)
         l = c_YEL;
      return l;
   endfunction

endpackage
`default_nettype wire

// File: rtl/intersection_scheduler_phase_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// intersection_scheduler_phase_timer : tick-enabled saturating phase counter
// Rev 1.0
// ------------------------------------------------------------------
module intersection_scheduler_phase_timer #(
   parameter int CNT_W = 4,
   parameter int SAT   = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_tick,
   input  logic [CNT_W-1:0] i_cmp,
   output logic [CNT_W-1:0] o_count,
   output logic             o_done
);

   localparam logic [CNT_W-1:0] c_SAT = CNT_W'(SAT);

   logic [CNT_W-1:0] r_count;

   // Clear has priority so a state change always starts the new phase at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= '0;
      else if (i_clr)
         r_count <= '0;
      else if (i_tick && (r_count != c_SAT))
         r_count <= r_count + CNT_W'(1);
   end

   assign o_count = r_count;
   assign o_done  = (r_count == i_cmp);

endmodule
`default_nettype wire

// File: rtl/intersection_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// intersection_scheduler : timed two-approach (V/B) traffic-light sequencer
// Rev 1.0
// ------------------------------------------------------------------
module intersection_scheduler
   import intersection_scheduler_pkg::*;
#(
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 12,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 2,
   parameter int CNT_W     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tick,
   input  logic       i_req_v,
   input  logic       i_req_b,
   input  logic [1:0] i_mode,
   output logic [2:0] o_light_v,
   output logic [2:0] o_light_b,
   output logic [2:0] o_phase,
   output logic       o_pend_v,
   output logic       o_pend_b
);

   localparam logic [CNT_W-1:0] c_GMIN = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] c_YCMP = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] c_ACMP = CNT_W'(ALLRED_T - 1);

   state_t           r_state;
   state_t           w_next;
   state_t           w_divert;
   logic             r_pend_v;
   logic             r_pend_b;
   logic             r_flash;
   logic             w_flash_nxt;
   logic [2:0]       r_light_v;
   logic [2:0]       r_light_b;
   logic [CNT_W-1:0] w_count;
   logic [CNT_W-1:0] w_cmp;
   logic             w_done;
   logic             w_clr;
   logic             w_normal;

   assign w_normal = is_normal(i_mode);
   assign w_divert = (i_mode == c_MODE_FLASH) ? ST_FLASH : ST_HOLD;
   assign w_cmp    = (r_state == ST_V_YEL || r_state == ST_B_YEL) ? c_YCMP : c_ACMP;
   assign w_clr    = (w_next != r_state);

   intersection_scheduler_phase_timer #(
      .CNT_W (CNT_W),
      .SAT   (GREEN_MAX - 1)
   ) u_phase_timer (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_clr),
      .i_tick  (i_tick),
      .i_cmp   (w_cmp),
      .o_count (w_count),
      .o_done  (w_done)
   );

   // Every transition is gated by tick; a pending diversion is taken at the end of clearance.
   always_comb begin
      w_next = r_state;
      if (i_tick) begin
         case (r_state)
            ST_CLR_V: if (w_done) w_next = w_normal ? ST_V_GRN : w_divert;
            ST_V_GRN: if (!w_normal || (r_pend_b && w_count >= c_GMIN)) w_next = ST_V_YEL;
            ST_V_YEL: if (w_done) w_next = ST_CLR_B;
            ST_CLR_B: if (w_done) w_next = w_normal ? ST_B_GRN : w_divert;
            ST_B_GRN: if (!w_normal || (r_pend_v && w_count >= c_GMIN)) w_next = ST_B_YEL;
            ST_B_YEL: if (w_done) w_next = ST_CLR_V;
            ST_FLASH: begin
               if (w_normal)                  w_next = ST_CLR_V;
               else if (i_mode == c_MODE_HOLD) w_next = ST_HOLD;
            end
            ST_HOLD: begin
               if (w_normal)                   w_next = ST_CLR_V;
               else if (i_mode == c_MODE_FLASH) w_next = ST_FLASH;
            end
            default: w_next = ST_CLR_V;
         endcase
      end
   end

   assign w_flash_nxt = (r_state != ST_FLASH) ? 1'b1 : (r_flash ^ i_tick);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_CLR_V;
         r_pend_v  <= 1'b0;
         r_pend_b  <= 1'b0;
         r_flash   <= 1'b0;
         r_light_v <= c_RED;
         r_light_b <= c_RED;
      end else begin
         r_state   <= w_next;
         r_flash   <= w_flash_nxt;
         r_light_v <= light_of(w_next, 1'b0, w_flash_nxt);
         r_light_b <= light_of(w_next, 1'b1, w_flash_nxt);
         // Green entry clears the latch even if the request is still asserted.
         r_pend_v  <= (w_next == ST_V_GRN && r_state != ST_V_GRN) ? 1'b0 : (r_pend_v | i_req_v);
         r_pend_b  <= (w_next == ST_B_GRN && r_state != ST_B_GRN) ? 1'b0 : (r_pend_b | i_req_b);
      end
   end

   assign o_light_v = r_light_v;
   assign o_light_b = r_light_b;
   assign o_phase   = r_state;
   assign o_pend_v  = r_pend_v;
   assign o_pend_b  = r_pend_b;

endmodule
`default_nettype wire

// File: doc/intersection_scheduler.md
# intersection_scheduler

Timed traffic-light scheduler that shares one intersection between two approaches, vehicular (V) and boat/bridge (B). It owns the phase state machine, the per-phase tick timers and the request latches, and drives the two 3-bit light outputs that downstream lamp drivers consume directly. It sits between the sensor/mode inputs and the lamp outputs, replacing hand-derived next-state equations with a parameterised, timer-driven sequencer.

## Interface
- GREEN_MIN, 4, minimum green length in ticks
- GREEN_MAX, 12, green length after which a pending opposing request forces a change
- YELLOW_T, 3, yellow length in ticks
- ALLRED_T, 2, all-red clearance length in ticks
- CNT_W, 4, timer width; must hold GREEN_MAX-1

- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high
- tick  in  1  one-cycle timing strobe; all timers advance only when tick=1
- req_v  in  1  V-approach demand sensor, level or pulse
- req_b  in  1  B-approach demand sensor, level or pulse
- mode  in  2  00/11 normal, 01 flash, 10 all-red hold
- light_v  out  3  {red, yellow, green}, one-hot except flash-off (000)
- light_b  out  3  same encoding for B
- phase  out  3  current state code, for debug/status
- pend_v, pend_b  out  1  latched demand flags

## Operation
- States: CLR_V (all-red, then V green), V_GRN, V_YEL, CLR_B, B_GRN, B_YEL, FLASH, HOLD.
- Reset: state CLR_V, timer 0, pend_v=pend_b=0, light_v=light_b=100 (red), phase=CLR_V code.
- Request latches: pend_x sets on any cycle req_x=1; cleared on entry to X green. A set and a clear in the same cycle: set wins only if req_x is high in the entry cycle is ignored — entry clears, and the request is re-latched the following cycle if still high.
- Timer: resets to 0 on every state change; increments on tick; saturates at GREEN_MAX-1.
- V_GRN: exit to V_YEL on tick when (pend_b and timer>=GREEN_MIN-1) or (pend_b and timer=GREEN_MAX-1). With pend_b=0, green holds indefinitely.
- V_YEL: exit to CLR_B on tick with timer=YELLOW_T-1. CLR_B: exit to B_GRN on tick with timer=ALLRED_T-1. B side is symmetric, through B_YEL and CLR_V to V_GRN.
- Mode non-normal while in a green state: go to that side's yellow on the next tick regardless of GREEN_MIN. Yellow then completes normally. The following clearance state completes, then enters FLASH (mode 01) or HOLD (mode 10) instead of the opposite green.
- Mode non-normal in a yellow or clear state: complete that state, then divert as above.
- FLASH: both yellows toggle on every tick (on first), red and green are off. HOLD: both red.
- Return to normal from FLASH/HOLD: enter CLR_V, then V_GRN. Mode 01↔10 switches directly between FLASH and HOLD.
- Invariant: never more than one side non-red outside FLASH; never green to green without a yellow and a clearance.

## Timing
- Outputs are registered and decoded from the state register. Lights change in the cycle after the tick that causes the transition.
- Phase lengths measured in ticks: yellow exactly YELLOW_T ticks, clearance exactly ALLRED_T ticks, green at least GREEN_MIN ticks in normal mode.
- tick=0 freezes all timers and transitions. Request latching continues.
- Reset asserted mid-phase forces all-red immediately (asynchronously), with no yellow.

## Structure
- Shared package: state enum, light constants (RED=100, YEL=010, GRN=001, OFF=000), mode constants.
- One sub-module, phase_timer: counter with clear, tick enable, saturation and a done/compare output. Instantiated once.

## Test plan
- Reset, tick every cycle, no requests → CLR_V for 2 ticks, then V_GRN (light_v=001, light_b=100), held indefinitely.
- In V_GRN, pulse req_b at timer=1 → pend_b=1; yellow at tick 4 (GREEN_MIN), 3 ticks yellow, 2 all-red, then light_b=001 and pend_b=0.
- Both requests held high continuously → strict alternation. Each green lasts exactly 4 ticks; no state ever shows both sides non-red.
- mode=01 during B_GRN at timer=0 → B_YEL next tick, 3 yellow ticks, 2 clear ticks, then FLASH with both lights toggling 010/000 on every tick. mode=00 → CLR_V, then V_GRN.
- tick held low for 20 cycles in V_YEL → state and lights frozen. Assert reset mid-V_YEL → both lights 100 in the same cycle, phase=CLR_V.
